crc_engine: RTL and testbench

Parametrised CRC generator/checker that replaces the fixed 8-bit serial shifter in the link datapath. It accumulates a CRC of configurable width and polynomial over frames that arrive 1 to N bits per cycle. Frame boundaries are marked by the producer, and the block signals frame completion with an optional residue check. It sits between the deserialiser and the frame validator.

---
 rtl/crc_engine.sv | 110 +++++++++++
 tb/tb_crc_engine.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
// Parametrised MSB-first Galois CRC generator/checker, DW bits per shift, framed by shift/last.
// Optional residue check of the final CRC is enabled by defining CRC_CHECK_EN.
module crc_engine #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(7),
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter int unsigned      DW      = 1,
  parameter logic [WIDTH-1:0] RESIDUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic [DW-1:0]    in,
  input  logic             last,
  output logic [WIDTH-1:0] crc,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [15:0]      bit_cnt
);

  localparam int unsigned CW  = 16;
  localparam int unsigned CSW = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, done_q, done_d, ok_q, ok_d;
  logic [WIDTH-1:0] seed_c, next_crc_c;
  logic [CSW-1:0]   cnt_sum_c;

  // DW unrolled LFSR steps, in[DW-1] consumed first
  function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] seed,
                                                input logic [DW-1:0] data);
    logic [WIDTH-1:0] c;
    logic             fb;
    c = seed;
    for (int i = int'(DW) - 1; i >= 0; i--) begin
      fb = c[WIDTH-1] ^ data[i];
      c  = {c[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  // A new frame (from IDLE or DONE) always restarts from INIT
  assign seed_c     = (state_q == RUN) ? crc_q : INIT;
  assign next_crc_c = crc_step(seed_c, in);
  assign cnt_sum_c  = {1'b0, cnt_q} + CSW'(DW);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    if (clr) begin
      state_d = IDLE;
      crc_d   = INIT;
      cnt_d   = '0;
    end else if (shift) begin
      crc_d = next_crc_c;
      if (state_q == RUN) begin
        cnt_d = cnt_sum_c[CSW-1] ? {CW{1'b1}} : cnt_sum_c[CW-1:0];
      end else begin
        cnt_d = CW'(DW);
      end
      if (last) begin
        state_d = DONE;
        done_d  = 1'b1;
`ifdef CRC_CHECK_EN
        ok_d    = (next_crc_c == RESIDUE);
`else
        ok_d    = 1'b0;
`endif
      end else begin
        state_d = RUN;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == RUN);
      done_q  <= done_d;
      ok_q    <= ok_d;
    end
  end

  assign crc     = crc_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign crc_ok  = ok_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_crc_engine.sv
// Scoreboard bench for crc_engine: CRC-8/0x07 with DW=8 and DW=1 instances.
module tb_crc_engine;

  typedef struct packed {
    logic [7:0]  crc;
    logic [15:0] cnt;
    logic        ok;
  } exp_t;

`ifdef CRC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr8, shift8, last8;
  logic [7:0]  in8;
  logic        shift1, last1;
  logic [0:0]  in1;
  logic [7:0]  crc8, crc1;
  logic        busy8, done8, ok8, busy1, done1, ok1;
  logic [15:0] cnt8, cnt1;

  exp_t q8[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  crc_engine #(.WIDTH(8), .POLY(8'h07), .INIT(8'h00), .DW(8), .RESIDUE(8'h00)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .shift(shift8), .in(in8), .last(last8),
    .crc(crc8), .busy(busy8), .done(done8), .crc_ok(ok8), .bit_cnt(cnt8)
  );

  crc_engine #(.WIDTH(8), .POLY(8'h07), .INIT(8'h00), .DW(1), .RESIDUE(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .shift(shift1), .in(in1), .last(last1),
    .crc(crc1), .busy(busy1), .done(done1), .crc_ok(ok1), .bit_cnt(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic l);
    shift8 = 1'b1; in8 = d; last8 = l;
    @(posedge clk); #1;
    shift8 = 1'b0; last8 = 1'b0;
  endtask

  task automatic send1(input logic b, input logic l);
    shift1 = 1'b1; in1 = b; last1 = l;
    @(posedge clk); #1;
    shift1 = 1'b0; last1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse is matched against the head of its scoreboard queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done8 === 1'b1) begin
        if (q8.size() == 0) chk("done8_unexpected", 32'(done8), 32'd0);
        else begin
          e = q8.pop_front();
          chk("dw8_crc", 32'(crc8), 32'(e.crc));
          chk("dw8_bit_cnt", 32'(cnt8), 32'(e.cnt));
          chk("dw8_crc_ok", 32'(ok8), 32'(e.ok));
        end
      end
      if (rst_n === 1'b1 && done1 === 1'b1) begin
        if (q1.size() == 0) chk("done1_unexpected", 32'(done1), 32'd0);
        else begin
          e = q1.pop_front();
          chk("dw1_crc", 32'(crc1), 32'(e.crc));
          chk("dw1_bit_cnt", 32'(cnt1), 32'(e.cnt));
          chk("dw1_crc_ok", 32'(ok1), 32'(e.ok));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bits;
    rst_n = 1'b0; clr8 = 1'b0; shift8 = 1'b0; last8 = 1'b0; in8 = '0;
    shift1 = 1'b0; last1 = 1'b0; in1 = '0;
    idle(2);
    chk("rst_crc", 32'(crc8), 32'h00);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_crc_ok", 32'(ok8), 32'd0);
    chk("rst_bit_cnt", 32'(cnt8), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // "123456789" -> 0xF4
    q8.push_back('{crc: 8'hF4, cnt: 16'd72, ok: 1'b0});
    send8(8'h31, 1'b0);
    chk("busy_after_first", 32'(busy8), 32'd1);
    for (int b = 8'h32; b <= 8'h38; b++) send8(8'(b), 1'b0);
    chk("busy_before_last", 32'(busy8), 32'd1);
    send8(8'h39, 1'b1);
    chk("busy_after_last", 32'(busy8), 32'd0);
    idle(2);

    // Appended good CRC then corrupted CRC, back to back
    q8.push_back('{crc: 8'h00, cnt: 16'd80, ok: CHK});
    for (int b = 8'h31; b <= 8'h39; b++) send8(8'(b), 1'b0);
    send8(8'hF4, 1'b1);
    q8.push_back('{crc: 8'h07, cnt: 16'd80, ok: 1'b0});
    for (int b = 8'h31; b <= 8'h39; b++) send8(8'(b), 1'b0);
    send8(8'hF5, 1'b1);
    idle(2);

    // Single-word frames back to back, second seeded from INIT
    q8.push_back('{crc: 8'h97, cnt: 16'd8, ok: 1'b0});
    q8.push_back('{crc: 8'h97, cnt: 16'd8, ok: 1'b0});
    send8(8'h31, 1'b1);
    send8(8'h31, 1'b1);
    idle(2);

    // clr with shift mid-frame drops the frame
    send8(8'h31, 1'b0);
    clr8 = 1'b1; shift8 = 1'b1; in8 = 8'h32; last8 = 1'b1;
    @(posedge clk); #1;
    clr8 = 1'b0; shift8 = 1'b0; last8 = 1'b0;
    chk("clr_crc", 32'(crc8), 32'h00);
    chk("clr_bit_cnt", 32'(cnt8), 32'd0);
    chk("clr_busy", 32'(busy8), 32'd0);
    chk("clr_done", 32'(done8), 32'd0);
    q8.push_back('{crc: 8'h97, cnt: 16'd8, ok: 1'b0});
    send8(8'h31, 1'b1);
    idle(2);

    // DW=1: bits of 0x31 with stalls
    bits = 8'h31;
    q1.push_back('{crc: 8'h97, cnt: 16'd8, ok: 1'b0});
    for (int i = 7; i >= 0; i--) begin
      send1(bits[i], (i == 0));
      if (i == 6 || i == 3) begin
        idle(3);
        chk("dw1_busy_stall", 32'(busy1), 32'd1);
      end
    end
    idle(2);

    // Asynchronous reset mid-frame
    send8(8'h31, 1'b0);
    send8(8'h32, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_crc", 32'(crc8), 32'h00);
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_bit_cnt", 32'(cnt8), 32'd0);
    chk("arst_done", 32'(done8), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(3);

    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
